serial_add8: RTL and testbench

Bit-serial restoring adder that reconstructs the minuend from the output of the team's 8-bit subtractor. Given the subtractor's difference `d`, its subtrahend `b` and its borrow flag, it computes `d + b` one bit per clock. It returns the reconstructed operand, the carry-out and a consistency flag. It sits downstream of the subtractor as its inverse, for self-check and for the datapath that must undo a subtraction.

---
 rtl/serial_add_pkg.sv | 13 +
 rtl/full_adder_1b.sv | 13 +
 rtl/serial_add8.sv | 103 ++++++++++
 tb/tb_serial_add8.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial restoring adder.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int SA_WIDTH = 8;
  localparam int SA_CNT_W = $clog2(SA_WIDTH + 1);

endpackage

// File: rtl/full_adder_1b.sv
// One-bit full adder used as the serial bit slice.
module full_adder_1b (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_add8.sv
// Bit-serial d + b, LSB first, one bit per clock; flags carry-out vs. the
// subtractor's borrow so an inconsistent difference/borrow pair is visible.
module serial_add8
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] a,
  output logic             cout,
  output logic             mismatch
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] d_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_nxt;
  logic             carry;
  logic             bin_q;
  logic [CNT_W-1:0] cnt;
  logic             sum;
  logic             cy;

  full_adder_1b u_fa (
    .x  (d_sr[0]),
    .y  (b_sr[0]),
    .ci (carry),
    .s  (sum),
    .co (cy)
  );

  assign res_nxt = {sum, res_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      d_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      carry    <= 1'b0;
      bin_q    <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      a        <= '0;
      cout     <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            d_sr   <= d;
            b_sr   <= b;
            bin_q  <= bin;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          d_sr   <= d_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_nxt;
          carry  <= cy;
          cnt    <= cnt + 1'b1;
          // Last bit: publish from the combinational slice so done lines up
          // with the WIDTH-th edge rather than one cycle later.
          if (cnt == CNT_W'(WIDTH - 1)) begin
            a        <= res_nxt;
            cout     <= cy;
            mismatch <= cy ^ bin_q;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add8.sv
// Scoreboard bench for serial_add8: expectations queued at drive time,
// popped and compared on each done pulse.
module tb_serial_add8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] d;
  logic [7:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] a;
  logic       cout;
  logic       mismatch;

  typedef struct packed {
    logic [7:0] a;
    logic       cout;
    logic       mm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  serial_add8 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .d        (d),
    .b        (b),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .a        (a),
    .cout     (cout),
    .mismatch (mismatch)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic exp_t model(input logic [7:0] dd, input logic [7:0] bb, input logic bi);
    exp_t       r;
    logic [8:0] s;
    s      = {1'b0, dd} + {1'b0, bb};
    r.a    = s[7:0];
    r.cout = s[8];
    r.mm   = s[8] ^ bi;
    return r;
  endfunction

  // Output monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (busy && done) chk("busy_done_excl", 1, 0);
    if (done) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("a", a, mon_e.a);
        chk("cout", cout, mon_e.cout);
        chk("mismatch", mismatch, mon_e.mm);
      end
    end
  end

  task automatic drive(input logic [7:0] dd, input logic [7:0] bb, input logic bi);
    start = 1'b1;
    d     = dd;
    b     = bb;
    bin   = bi;
    sb.push_back(model(dd, bb, bi));
  endtask

  // Called just after the accept edge; returns at the negedge where done is seen.
  task automatic wait_done(input int mode, output int lat, output int nb);
    lat = 0;
    nb  = 0;
    while (1'b1) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) begin
        if (mode == 1) begin
          start = 1'b1; d = 8'hAA; b = 8'h33;
        end
        break;
      end
      lat++;
      if (mode == 1 && lat == 3) begin
        start = 1'b1; d = 8'hC3; b = 8'h5A; bin = 1'b1;
      end
      if (mode == 1 && lat == 4) start = 1'b0;
      if (lat > 20) begin
        chk("done_timeout", 0, 1);
        break;
      end
    end
  endtask

  // mode 0: plain, 1: start pulses during SHIFT and DONE, 2: operands change after load
  task automatic run_op(input logic [7:0] dd, input logic [7:0] bb, input logic bi, input int mode);
    int         lat;
    int         nb;
    logic [7:0] keep;
    drive(dd, bb, bi);
    @(posedge clk);
    #1 start = 1'b0;
    if (mode == 2) begin
      d = ~dd; b = bb + 8'h11; bin = ~bi;
    end
    wait_done(mode, lat, nb);
    chk("latency", lat, 8);
    chk("busy_cycles", nb, 8);
    @(negedge clk);
    start = 1'b0;
    if (mode == 1) begin
      keep = a;
      repeat (12) @(negedge clk);
      chk("a_hold_after_ignored", a, keep);
      chk("idle_after_ignored", busy, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int nb;
    int t1;
    rst_n = 1'b0;
    start = 1'b0;
    d     = '0;
    b     = '0;
    bin   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_a", a, 0);
    chk("rst_cout", cout, 0);
    chk("rst_mismatch", mismatch, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'hFE, 8'h01, 1'b0, 0);
    run_op(8'h07, 8'hFB, 1'b1, 0);
    run_op(8'hFD, 8'h04, 1'b1, 0);
    run_op(8'h00, 8'hFF, 1'b0, 0);
    run_op(8'h08, 8'h10, 1'b1, 0);
    run_op(8'h3C, 8'h0A, 1'b0, 1);
    run_op(8'h5A, 8'hA5, 1'b1, 2);

    // Abort after three bits: nothing queued, so any done pulse is flagged.
    start = 1'b1; d = 8'h55; b = 8'h11; bin = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_a", a, 0);
    chk("midrst_cout", cout, 0);
    chk("midrst_mismatch", mismatch, 0);

    // Start held while reset releases: accepted on the first clean edge.
    @(negedge clk);
    drive(8'h81, 8'h7F, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(0, lat, nb);
    chk("rst_release_latency", lat, 8);
    @(negedge clk);

    // Back-to-back with start held high, operands switched between accepts.
    drive(8'h01, 8'h01, 1'b0);
    @(posedge clk);
    #1;
    wait_done(0, lat, nb);
    chk("b2b_latency", lat, 8);
    t1 = cyc;
    d  = 8'hFF;
    b  = 8'h00;
    bin = 1'b0;
    sb.push_back(model(8'hFF, 8'h00, 1'b0));
    wait_done(0, lat, nb);
    chk("b2b_period", cyc - t1, 10);
    start = 1'b0;

    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
